// File: rtl/vt151_sched_pkg.sv
// Shared types and helpers for the 8-way shared-mux scheduler and its arbiters.
package vt151_sched_pkg;

  localparam int NREQ  = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } sched_state_e;

  function automatic logic [NREQ-1:0] onehot3to8(input logic [SEL_W-1:0] sel);
    logic [NREQ-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/vt151_rr_sched_if.sv
// Requester/mux-control bundle between the scheduler (master) and its clients (slave).
interface vt151_rr_sched_if;

  logic [vt151_sched_pkg::NREQ-1:0]  req;
  logic [vt151_sched_pkg::NREQ-1:0]  gnt;
  logic                              mux_e_n;
  logic [vt151_sched_pkg::SEL_W-1:0] mux_s;
  logic [vt151_sched_pkg::SEL_W-1:0] owner;
  logic                              busy;
  logic                              preempt;

  modport master (
    input  req,
    output gnt, mux_e_n, mux_s, owner, busy, preempt
  );

  modport slave (
    output req,
    input  gnt, mux_e_n, mux_s, owner, busy, preempt
  );

endinterface

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping mod 8.
module rr_pick8
  import vt151_sched_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             vld,
  output logic [SEL_W-1:0] idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [SEL_W-1:0]  off;
  logic [SEL_W:0]    ptr_x;

  always_comb begin
    ptr_x = {1'b0, ptr};
    dbl   = {req, req};
    // rot[0] is the requester at ptr, so the lowest set bit is the winner
    rot   = dbl[ptr_x +: NREQ];
    off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    vld = |req;
    idx = ptr + off;
  end

endmodule

// File: rtl/vt151_rr_sched.sv
// Round-robin owner scheduler for a shared 74LS151-style mux; grant registered one edge after req sampled.
// Break-before-make: one IDLE cycle plus GAP_CYC disabled cycles between owners; optional hold timeout.
module vt151_rr_sched
  import vt151_sched_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int GAP_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  vt151_rr_sched_if.master bus
);

  localparam int HOLD_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam int GAP_W  = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_MAX);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_GRANT = GRANT;
  localparam logic [1:0] S_GAP   = GAP;

  logic [1:0]        state;
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  sel;
  logic [HOLD_W-1:0] hold_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [NREQ-1:0]   gnt;
  logic              mux_e_n;
  logic              busy;
  logic              preempt;

  logic              pick_vld;
  logic [SEL_W-1:0]  pick_idx;
  logic              owner_rel;
  logic              others_pend;
  logic              hold_tmo;

  rr_pick8 u_pick (
    .req (bus.req),
    .ptr (ptr),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  always_comb begin
    owner_rel   = ~bus.req[sel];
    others_pend = |(bus.req & ~onehot3to8(sel));
    hold_tmo    = (HOLD_MAX > 0) && (hold_cnt == HOLD_LAST) && others_pend;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      sel      <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      gnt      <= '0;
      mux_e_n  <= 1'b1;
      busy     <= 1'b0;
      preempt  <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            gnt      <= onehot3to8(pick_idx);
            sel      <= pick_idx;
            mux_e_n  <= 1'b0;
            busy     <= 1'b1;
            hold_cnt <= '0;
            state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + 1'b1;
          // a voluntary release wins over a coincident timeout
          if (owner_rel || hold_tmo) begin
            gnt     <= '0;
            mux_e_n <= 1'b1;
            busy    <= 1'b0;
            ptr     <= sel + 1'b1;
            preempt <= ~owner_rel;
            gap_cnt <= '0;
            if (GAP_CYC > 0) state <= S_GAP;
            else             state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state <= S_IDLE;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt;
  assign bus.mux_e_n = mux_e_n;
  assign bus.mux_s   = sel;
  assign bus.owner   = sel;
  assign bus.busy    = busy;
  assign bus.preempt = preempt;

endmodule

// File: tb/tb_vt151_rr_sched.sv
// Scoreboard bench for vt151_rr_sched: cycle model predicts outputs, plus directed scenario checks.
module tb_vt151_rr_sched;
  import vt151_sched_pkg::*;

  localparam int HOLD_MAX = 16;
  localparam int GAP_CYC  = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  vt151_rr_sched_if bus ();

  vt151_rr_sched #(.HOLD_MAX(HOLD_MAX), .GAP_CYC(GAP_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [16:0] exp_q[$];
  logic [7:0]  prev_gnt;

  // reference model state
  int         m_state;
  int         m_hold;
  int         m_gap;
  logic [2:0] m_ptr;
  logic [2:0] m_sel;
  logic [7:0] m_gnt;
  logic       m_en_n;
  logic       m_busy;
  logic       m_pre;

  // scenario bookkeeping
  logic [7:0] r;
  logic [7:0] pg;
  int         exp_order[$];
  int         ngr, dead, len5, len4, cnt1, npre, bad;
  logic       done5, next_chk, seen5b, gone4, seen6, found;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] obs();
    return {bus.gnt, bus.mux_e_n, bus.mux_s, bus.owner, bus.busy, bus.preempt};
  endfunction

  task automatic model_reset();
    m_state = 0; m_hold = 0; m_gap = 0; m_ptr = 3'd0; m_sel = 3'd0;
    m_gnt = 8'h00; m_en_n = 1'b1; m_busy = 1'b0; m_pre = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] rq);
    logic       rel, tmo;
    logic [7:0] others;
    int         j;
    m_pre = 1'b0;
    case (m_state)
      0: begin
        for (int k = 0; k < 8; k++) begin
          j = (int'(m_ptr) + k) % 8;
          if (rq[j]) begin
            m_gnt = 8'(1 << j); m_sel = 3'(j); m_en_n = 1'b0; m_busy = 1'b1;
            m_hold = 0; m_state = 1;
            break;
          end
        end
      end
      1: begin
        others = rq & ~(8'h01 << m_sel);
        rel    = !rq[m_sel];
        tmo    = (HOLD_MAX > 0) && (m_hold == HOLD_MAX - 1) && (others != 8'h00);
        if (m_hold < HOLD_MAX) m_hold++;
        if (rel || tmo) begin
          m_gnt = 8'h00; m_en_n = 1'b1; m_busy = 1'b0; m_ptr = m_sel + 3'd1;
          m_pre = !rel; m_gap = 0;
          m_state = (GAP_CYC > 0) ? 2 : 0;
        end
      end
      default: begin
        m_gap++;
        if (m_gap >= GAP_CYC) m_state = 0;
      end
    endcase
  endtask

  task automatic step(input logic [7:0] rq);
    logic [16:0] e;
    logic        ok_oh, ok_b, ok_adj;
    bus.req = rq;
    model_step(rq);
    exp_q.push_back({m_gnt, m_en_n, m_sel, m_sel, m_busy, m_pre});
    @(posedge clk); #1;
    check("sb_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_cycle", obs(), e);
    end
    ok_oh  = ($countones(bus.gnt) <= 1);
    ok_b   = ((bus.gnt != 0) == bus.busy) && ((bus.gnt != 0) == !bus.mux_e_n);
    ok_adj = !(prev_gnt != 0 && bus.gnt != 0 && bus.gnt != prev_gnt);
    check("invariants", {29'b0, ok_oh, ok_b, ok_adj}, 32'h7);
    prev_gnt = bus.gnt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.req = 8'h00; prev_gnt = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", obs(), {8'h00, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0});
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req = 8'h00;

    // single request, then pointer lands on owner+1
    do_reset();
    step(8'h04);
    check("single_gnt", bus.gnt, 8'h04);
    check("single_sel", bus.mux_s, 3'd2);
    check("single_en", bus.mux_e_n, 1'b0);
    step(8'h04); step(8'h04);
    step(8'h00);
    check("single_rel_en", bus.mux_e_n, 1'b1);
    repeat (3) step(8'h00);
    step(8'h0C);
    check("ptr_after_rel", bus.owner, 3'd3);
    repeat (4) step(8'h00);

    // full rotation, 3-cycle holds
    do_reset();
    for (int i = 0; i < 8; i++) exp_order.push_back(i);
    exp_order.push_back(0);
    ngr = 0; dead = 0; pg = 8'h00;
    for (int t = 0; t < 80 && ngr < 9; t++) begin
      r = 8'hFF;
      if (m_busy && m_hold == 2) r[m_sel] = 1'b0;
      step(r);
      if (bus.gnt != 0 && pg == 0) begin
        if (ngr > 0) check("rot_dead", dead, 2);
        check("rot_order", bus.owner, exp_order.pop_front());
        ngr++; dead = 0;
      end else if (bus.mux_e_n) begin
        dead++;
      end
      pg = bus.gnt;
    end
    check("rot_count", ngr, 9);

    // preemption by timeout with contender on req[1]
    do_reset();
    len5 = 0; cnt1 = 0; npre = 0; done5 = 0; next_chk = 0; seen5b = 0;
    for (int t = 0; t < 80; t++) begin
      r = 8'h20;
      if (t >= 4)    r[1] = 1'b1;
      if (cnt1 >= 3) r[1] = 1'b0;
      step(r);
      if (bus.preempt) begin
        npre++; done5 = 1'b1;
        check("pre_gnt_low", bus.gnt, 8'h00);
      end
      if (!done5 && bus.gnt == 8'h20) len5++;
      if (done5 && !next_chk && bus.gnt != 0) begin
        next_chk = 1'b1;
        check("pre_next_owner", bus.owner, 3'd1);
      end
      if (bus.gnt == 8'h02) cnt1++;
      if (cnt1 > 0 && bus.gnt == 8'h20) seen5b = 1'b1;
    end
    check("pre_len", len5, 16);
    check("pre_pulses", npre, 1);
    check("pre_len1", cnt1, 3);
    check("pre_return5", seen5b, 1'b1);

    // long hold with no contention never drops
    do_reset();
    bad = 0; npre = 0;
    for (int t = 0; t < 100; t++) begin
      step(8'h08);
      if (bus.gnt != 8'h08) bad++;
      if (bus.preempt) npre++;
    end
    check("tmo_drop", bad, 0);
    check("tmo_pre", npre, 0);
    repeat (3) step(8'h00);

    // release coinciding with timeout counts as release
    do_reset();
    npre = 0; len4 = 0; gone4 = 0; seen6 = 0;
    for (int t = 0; t < 40; t++) begin
      if (m_busy && m_sel == 3'd4 && m_hold == HOLD_MAX - 1) gone4 = 1'b1;
      r = gone4 ? 8'h00 : 8'h10;
      if (t >= 2) r[6] = 1'b1;
      step(r);
      if (bus.preempt) npre++;
      if (bus.gnt == 8'h10) len4++;
      if (bus.gnt == 8'h40) seen6 = 1'b1;
    end
    check("both_pre", npre, 0);
    check("both_len", len4, 16);
    check("both_next6", seen6, 1'b1);

    // pointer wrap 7 -> 0
    do_reset();
    step(8'h80);
    check("wrap_own7", bus.gnt, 8'h80);
    step(8'h81); step(8'h81); step(8'h01);
    found = 1'b0;
    for (int t = 0; t < 6 && !found; t++) begin
      step(8'h01);
      if (bus.gnt != 0) begin
        found = 1'b1;
        check("wrap_gnt", bus.gnt, 8'h01);
      end
    end
    check("wrap_found", found, 1'b1);

    // asynchronous reset mid-grant
    do_reset();
    step(8'h08); step(8'h08);
    check("arst_pre", bus.gnt, 8'h08);
    #2 rst_n = 1'b0;
    #1;
    check("arst_gnt", bus.gnt, 8'h00);
    check("arst_en", bus.mux_e_n, 1'b1);
    check("arst_busy", bus.busy, 1'b0);
    model_reset();
    prev_gnt = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(8'h80);
    check("arst_regrant", bus.gnt, 8'h80);
    repeat (3) step(8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
